sblk_act_feeder: RTL and testbench

SBLK_ACT_FEEDER -- requirements
Module: sblk_act_feeder

---
 rtl/sblk_pkg.sv | 34 +++
 rtl/sblk_act_feeder.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_sblk_act_feeder.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sblk_pkg.sv
// Shared sblk definitions: instruction field widths, the decoded
// instruction layout and the activation-feeder FSM state encoding.
package sblk_pkg;

   localparam int SBLK_WID_INST_TN = 4;
   localparam int SBLK_WID_INST_TM = 9;
   localparam int SBLK_WID_INST_TP = 5;
   localparam int SBLK_WID_INST_LN = 5;
   localparam int SBLK_WID_INST_LP = 5;
   localparam int SBLK_WID_INST    = SBLK_WID_INST_TN + SBLK_WID_INST_TM +
                                     SBLK_WID_INST_TP + SBLK_WID_INST_LN +
                                     SBLK_WID_INST_LP;

   // Instruction word, n_tn in the LSBs up to n_lp in the MSBs.
   typedef struct packed {
      logic [SBLK_WID_INST_LP-1:0] n_lp;
      logic [SBLK_WID_INST_LN-1:0] n_ln;
      logic [SBLK_WID_INST_TP-1:0] n_tp;
      logic [SBLK_WID_INST_TM-1:0] n_tm;
      logic [SBLK_WID_INST_TN-1:0] n_tn;
   } sblk_inst_t;

   typedef enum logic [1:0] {
      SBLK_ST_IDLE  = 2'd0,
      SBLK_ST_BURST = 2'd1,
      SBLK_ST_DRAIN = 2'd2
   } sblk_state_e;

   // Reinterpret a raw instruction word as its fields.
   function automatic sblk_inst_t sblk_decode(input logic [SBLK_WID_INST-1:0] raw);
      return sblk_inst_t'(raw);
   endfunction

endpackage

// File: rtl/sblk_act_feeder.sv
// sblk_act_feeder: streams one batch of L = n_tp*n_tn*N_TILE activation
// words from the source memory per request from sblk_ctrl. Source reads
// have a fixed 1-cycle latency and are presented straight to act_data.
// Build option SBLK_ACT_FEEDER_REQ_QUEUE_EN: hold one request that arrives
// during a burst and start it right after DRAIN. Without it such requests
// are dropped. req_drop pulses for every request that is thrown away.
module sblk_act_feeder
   import sblk_pkg::*;
#(
   parameter int N_TILE      = 4,
   parameter int WID_ACT     = 16,
   parameter int WID_SRCADDR = 12,
   parameter int WID_INST_TN = SBLK_WID_INST_TN,
   parameter int WID_INST_TM = SBLK_WID_INST_TM,
   parameter int WID_INST_TP = SBLK_WID_INST_TP,
   parameter int WID_INST_LN = SBLK_WID_INST_LN,
   parameter int WID_INST_LP = SBLK_WID_INST_LP,
   parameter int WID_INST    = WID_INST_TN + WID_INST_TM + WID_INST_TP +
                               WID_INST_LN + WID_INST_LP
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WID_INST-1:0]    inst_data,
   input  logic                   inst_en,
   input  logic [WID_SRCADDR-1:0] src_base,
   input  logic                   act_data_in_req,
   output logic                   act_data_in_vld,
   output logic [WID_ACT-1:0]     act_data,
   output logic                   src_rd_en,
   output logic [WID_SRCADDR-1:0] src_rd_addr,
   input  logic [WID_ACT-1:0]     src_rd_data,
   output logic                   busy,
   output logic                   batch_done,
   output logic                   req_drop
);

   localparam int OFS_TM = WID_INST_TN;
   localparam int OFS_TP = OFS_TM + WID_INST_TM;
   localparam int OFS_LN = OFS_TP + WID_INST_TP;
   localparam int OFS_LP = OFS_LN + WID_INST_LN;

   sblk_state_e            r_state;
   sblk_state_e            w_nxt_state;

   logic [WID_INST_TN-1:0] r_n_tn;
   logic [WID_INST_TM-1:0] r_n_tm;
   logic [WID_INST_TP-1:0] r_n_tp;
   logic [WID_INST_LN-1:0] r_n_ln;
   logic [WID_INST_LP-1:0] r_n_lp;
   logic [WID_SRCADDR-1:0] r_src_base;
   logic                   r_inst_d1;
   logic [15:0]            r_len;

   logic [WID_INST_LP-1:0] r_bidx;
   logic [WID_SRCADDR-1:0] r_off;
   logic                   r_pend;
   logic                   r_rd_en;
   logic [WID_SRCADDR-1:0] r_rd_addr;
   logic [15:0]            r_rem;
   logic                   r_last_rd;
   logic                   r_busy;
   logic                   r_drop;
   logic                   r_vld;
   logic                   r_done;
   logic [WID_ACT-1:0]     r_act_hold;

   logic [15:0]            w_len_calc;
   logic [WID_SRCADDR-1:0] w_off_step;
   logic [WID_INST_LP-1:0] w_lp_eff;
   logic [WID_INST_LP-1:0] w_bidx_inc;
   logic                   w_req_ok;
   logic                   w_start;
   logic                   w_nxt_rd_en;
   logic [WID_SRCADDR-1:0] w_nxt_addr;
   logic [15:0]            w_nxt_rem;
   logic                   w_nxt_last;
   logic                   w_nxt_zdone;
   logic                   w_nxt_pend;
   logic                   w_nxt_drop;
   logic                   w_nxt_busy;
   logic [WID_INST_LP-1:0] w_nxt_bidx;
   logic [WID_SRCADDR-1:0] w_nxt_off;
   logic [WID_ACT-1:0]     w_act;
   logic                   w_unused_fields;

   // n_tm and n_ln are carried for sblk_ctrl but do not shape the feed.
   assign w_unused_fields = ^{r_n_tm, r_n_ln};

   assign w_len_calc = 16'(r_n_tp) * 16'(r_n_tn) * 16'(N_TILE);
   assign w_off_step = WID_SRCADDR'(r_len);
   assign w_lp_eff   = (r_n_lp == {WID_INST_LP{1'b0}}) ? WID_INST_LP'(1'b1) : r_n_lp;
   assign w_bidx_inc = r_bidx + WID_INST_LP'(1'b1);
   // A request is only meaningful once L has settled after an instruction.
   assign w_req_ok   = act_data_in_req & ~inst_en & ~r_inst_d1;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SBLK_ST_IDLE;
      end else begin
         r_state <= w_nxt_state;
      end
   end

   // Capture instruction fields and source base on the load strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_n_tn     <= {WID_INST_TN{1'b0}};
         r_n_tm     <= {WID_INST_TM{1'b0}};
         r_n_tp     <= {WID_INST_TP{1'b0}};
         r_n_ln     <= {WID_INST_LN{1'b0}};
         r_n_lp     <= {WID_INST_LP{1'b0}};
         r_src_base <= {WID_SRCADDR{1'b0}};
         r_inst_d1  <= 1'b0;
      end else begin
         r_inst_d1 <= inst_en;
         if (inst_en) begin
            r_n_tn     <= inst_data[0 +: WID_INST_TN];
            r_n_tm     <= inst_data[OFS_TM +: WID_INST_TM];
            r_n_tp     <= inst_data[OFS_TP +: WID_INST_TP];
            r_n_ln     <= inst_data[OFS_LN +: WID_INST_LN];
            r_n_lp     <= inst_data[OFS_LP +: WID_INST_LP];
            r_src_base <= src_base;
         end
      end
   end

   // Batch length follows the registered fields one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_len <= 16'd0;
      end else begin
         r_len <= w_len_calc;
      end
   end

   // Next-state, read issue, request acceptance and batch bookkeeping.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_rd_en = 1'b0;
      w_nxt_addr  = r_rd_addr;
      w_nxt_rem   = r_rem;
      w_nxt_last  = 1'b0;
      w_nxt_zdone = 1'b0;
      w_nxt_pend  = r_pend;
      w_nxt_drop  = 1'b0;
      w_nxt_bidx  = r_bidx;
      w_nxt_off   = r_off;
      w_start     = 1'b0;
      case (r_state)
         SBLK_ST_IDLE: begin
            w_start = w_req_ok;
         end
         SBLK_ST_BURST: begin
            if (r_rem == 16'd0) begin
               w_nxt_state = SBLK_ST_DRAIN;
            end else begin
               w_nxt_rd_en = 1'b1;
               w_nxt_addr  = r_rd_addr + WID_SRCADDR'(1'b1);
               w_nxt_rem   = r_rem - 16'd1;
               w_nxt_last  = (r_rem == 16'd1);
            end
`ifdef SBLK_ACT_FEEDER_REQ_QUEUE_EN
            if (w_req_ok && r_pend) begin
               w_nxt_drop = 1'b1;
            end else if (w_req_ok) begin
               w_nxt_pend = 1'b1;
            end else begin
               w_nxt_drop = 1'b0;
            end
`else
            w_nxt_drop = w_req_ok;
`endif
         end
         SBLK_ST_DRAIN: begin
            w_nxt_state = SBLK_ST_IDLE;
`ifdef SBLK_ACT_FEEDER_REQ_QUEUE_EN
            if (r_pend) begin
               // The queued request wins; a fresh one now has nowhere to go.
               w_start    = 1'b1;
               w_nxt_pend = 1'b0;
               w_nxt_drop = w_req_ok;
            end else begin
               w_start = w_req_ok;
            end
`else
            w_nxt_drop = w_req_ok;
`endif
         end
         default: begin
            w_nxt_state = SBLK_ST_IDLE;
         end
      endcase

      if (w_start) begin
         w_nxt_addr = r_src_base + r_off;
         if (r_len == 16'd0) begin
            // Empty batch: no reads, just the completion pulse.
            w_nxt_state = SBLK_ST_IDLE;
            w_nxt_zdone = 1'b1;
         end else begin
            w_nxt_state = SBLK_ST_BURST;
            w_nxt_rd_en = 1'b1;
            w_nxt_rem   = r_len - 16'd1;
            w_nxt_last  = (r_len == 16'd1);
         end
         // Advance to the next batch offset now; wrap after n_lp batches.
         if (w_bidx_inc >= w_lp_eff) begin
            w_nxt_bidx = {WID_INST_LP{1'b0}};
            w_nxt_off  = {WID_SRCADDR{1'b0}};
         end else begin
            w_nxt_bidx = w_bidx_inc;
            w_nxt_off  = r_off + w_off_step;
         end
      end else begin
         w_nxt_zdone = 1'b0;
      end

      // A new instruction cancels everything still to be issued.
      if (inst_en) begin
         w_nxt_state = SBLK_ST_IDLE;
         w_nxt_rd_en = 1'b0;
         w_nxt_last  = 1'b0;
         w_nxt_zdone = 1'b0;
         w_nxt_pend  = 1'b0;
         w_nxt_drop  = 1'b0;
         w_nxt_bidx  = {WID_INST_LP{1'b0}};
         w_nxt_off   = {WID_SRCADDR{1'b0}};
      end else begin
         w_nxt_pend = w_nxt_pend;
      end

      w_nxt_busy = (w_nxt_state != SBLK_ST_IDLE) | w_nxt_pend;
   end

   // Register the read port, counters and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_en   <= 1'b0;
         r_rd_addr <= {WID_SRCADDR{1'b0}};
         r_rem     <= 16'd0;
         r_last_rd <= 1'b0;
         r_pend    <= 1'b0;
         r_drop    <= 1'b0;
         r_bidx    <= {WID_INST_LP{1'b0}};
         r_off     <= {WID_SRCADDR{1'b0}};
         r_busy    <= 1'b0;
      end else begin
         r_rd_en   <= w_nxt_rd_en;
         r_rd_addr <= w_nxt_addr;
         r_rem     <= w_nxt_rem;
         r_last_rd <= w_nxt_last;
         r_pend    <= w_nxt_pend;
         r_drop    <= w_nxt_drop;
         r_bidx    <= w_nxt_bidx;
         r_off     <= w_nxt_off;
         r_busy    <= w_nxt_busy;
      end
   end

   // Track returning read data; reads in flight are never cancelled.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld      <= 1'b0;
         r_done     <= 1'b0;
         r_act_hold <= {WID_ACT{1'b0}};
      end else begin
         r_vld      <= r_rd_en;
         r_done     <= r_last_rd | w_nxt_zdone;
         r_act_hold <= w_act;
      end
   end

   // Read data passes through while valid, otherwise the last word is held.
   assign w_act = r_vld ? src_rd_data : r_act_hold;

   assign act_data_in_vld = r_vld;
   assign act_data        = w_act;
   assign src_rd_en       = r_rd_en;
   assign src_rd_addr     = r_rd_addr;
   assign busy            = r_busy;
   assign batch_done      = r_done;
   assign req_drop        = r_drop;

endmodule

// File: tb/tb_sblk_act_feeder.sv
// Self-checking bench for sblk_act_feeder: table vectors, hand-written
// corner sequences and randomized instructions against an address model.
module tb_sblk_act_feeder;

   logic        clk;
   logic        rst;
   logic [27:0] inst_data;
   logic        inst_en;
   logic [11:0] src_base;
   logic        act_data_in_req;
   logic        act_data_in_vld;
   logic [15:0] act_data;
   logic        src_rd_en;
   logic [11:0] src_rd_addr;
   logic [15:0] src_rd_data;
   logic        busy;
   logic        batch_done;
   logic        req_drop;

   int          checks;
   int          failures;
   logic [15:0] salt;

   typedef struct {
      int          tn;
      int          tp;
      int          lp;
      logic [11:0] base;
      int          exp_len;
      logic [11:0] exp_start2;
   } vec_t;

   vec_t tbl[4];

   sblk_act_feeder dut (
      .clk             (clk),
      .rst             (rst),
      .inst_data       (inst_data),
      .inst_en         (inst_en),
      .src_base        (src_base),
      .act_data_in_req (act_data_in_req),
      .act_data_in_vld (act_data_in_vld),
      .act_data        (act_data),
      .src_rd_en       (src_rd_en),
      .src_rd_addr     (src_rd_addr),
      .src_rd_data     (src_rd_data),
      .busy            (busy),
      .batch_done      (batch_done),
      .req_drop        (req_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory content is a bijective function of the address.
   function automatic logic [15:0] mem_val(input logic [11:0] a);
      return (16'(a) * 16'h9E37) ^ salt;
   endfunction

   // Source memory: data one cycle after the read; junk when not reading.
   always @(posedge clk) begin
      if (src_rd_en) src_rd_data <= mem_val(src_rd_addr);
      else           src_rd_data <= mem_val(src_rd_addr) ^ 16'h5A5A;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " vld"},   32'(act_data_in_vld), 32'd0);
      chk({nm, " data"},  32'(act_data),        32'd0);
      chk({nm, " rd_en"}, 32'(src_rd_en),       32'd0);
      chk({nm, " addr"},  32'(src_rd_addr),     32'd0);
      chk({nm, " busy"},  32'(busy),            32'd0);
      chk({nm, " done"},  32'(batch_done),      32'd0);
      chk({nm, " drop"},  32'(req_drop),        32'd0);
   endtask

   // Called at a negedge; returns two negedges later with L settled.
   task automatic load_inst(input int tn, input int tp, input int lp, input logic [11:0] base);
      inst_data = {5'(lp), 5'd3, 5'(tp), 9'd7, 4'(tn)};
      src_base  = base;
      inst_en   = 1'b1;
      @(negedge clk);
      inst_en   = 1'b0;
      @(negedge clk);
   endtask

   // One request from idle, then the whole expected batch cycle by cycle.
   task automatic run_batch(input logic [11:0] start, input int len, input string nm);
      int          errs;
      logic [11:0] a;
      act_data_in_req = 1'b1;
      @(negedge clk);
      act_data_in_req = 1'b0;
      if (len == 0) begin
         chk({nm, " empty done"}, 32'(batch_done),      32'd1);
         chk({nm, " empty vld"},  32'(act_data_in_vld), 32'd0);
         @(negedge clk);
         chk({nm, " empty done pulse"}, 32'(batch_done),      32'd0);
         chk({nm, " empty vld after"},  32'(act_data_in_vld), 32'd0);
      end else begin
         chk({nm, " first rd_en"}, 32'(src_rd_en),       32'd1);
         chk({nm, " first addr"},  32'(src_rd_addr),     32'(start));
         chk({nm, " early vld"},   32'(act_data_in_vld), 32'd0);
         chk({nm, " busy"},        32'(busy),            32'd1);
         errs = 0;
         for (int w = 0; w < len; w++) begin
            @(negedge clk);
            a = 12'(32'(start) + w);
            if (act_data_in_vld !== 1'b1 || act_data !== mem_val(a) ||
                batch_done !== (w == len - 1)) errs++;
         end
         chk({nm, " burst words"}, 32'(errs), 32'd0);
         @(negedge clk);
         chk({nm, " vld after"},  32'(act_data_in_vld), 32'd0);
         chk({nm, " idle busy"},  32'(busy),            32'd0);
         chk({nm, " done after"}, 32'(batch_done),      32'd0);
         chk({nm, " data hold"},  32'(act_data), 32'(mem_val(12'(32'(start) + len - 1))));
      end
   endtask

   initial begin
      #10000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nv;
      int nd;
      int ninth;
      int tn;
      int tp;
      int lp;
      int lpe;
      int len;
      int nreq;
      logic [11:0] base;

      checks          = 0;
      failures        = 0;
      salt            = 16'($urandom);
      rst             = 1'b1;
      inst_data       = 28'd0;
      inst_en         = 1'b0;
      src_base        = 12'd0;
      act_data_in_req = 1'b0;
      src_rd_data     = 16'd0;

      tbl[0] = '{3,  1, 0, 12'h7F0, 12,  12'h7F0};
      tbl[1] = '{1,  1, 3, 12'hFFE, 4,   12'h002};
      tbl[2] = '{15, 2, 2, 12'h000, 120, 12'h078};
      tbl[3] = '{5,  0, 2, 12'h300, 0,   12'h300};

      // Reset state.
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Reference burst: L=24 from 0x100.
      load_inst(2, 3, 1, 12'h100);
      run_batch(12'h100, 24, "ref24");

      // n_lp=2: offsets 0, L, 0.
      load_inst(1, 2, 2, 12'h020);
      run_batch(12'h020, 8, "lp2 b0");
      run_batch(12'h028, 8, "lp2 b1");
      run_batch(12'h020, 8, "lp2 b2");

      // Table vectors: two batches each.
      for (int i = 0; i < 4; i++) begin
         load_inst(tbl[i].tn, tbl[i].tp, tbl[i].lp, tbl[i].base);
         run_batch(tbl[i].base,       tbl[i].exp_len, "table b0");
         run_batch(tbl[i].exp_start2, tbl[i].exp_len, "table b1");
      end

      // Requests with inst_en and in the following cycle are ignored.
      inst_data       = {5'd1, 5'd3, 5'd1, 9'd7, 4'd1};
      src_base        = 12'h0A0;
      inst_en         = 1'b1;
      act_data_in_req = 1'b1;
      @(negedge clk);
      inst_en = 1'b0;
      @(negedge clk);
      act_data_in_req = 1'b0;
      chk("settle busy",  32'(busy),      32'd0);
      chk("settle rd_en", 32'(src_rd_en), 32'd0);
      @(negedge clk);
      chk("settle busy later", 32'(busy), 32'd0);
      run_batch(12'h0A0, 4, "after settle");

      // Request during a burst.
      load_inst(1, 2, 1, 12'h040);
      act_data_in_req = 1'b1;
      @(negedge clk);
      act_data_in_req = 1'b0;
      nv = 0; nd = 0; ninth = 0;
      for (int c = 1; c <= 24; c++) begin
         if (act_data_in_vld) begin
            nv++;
            if (nv == 9) ninth = c;
         end
         if (req_drop) nd++;
         act_data_in_req = (c == 3);
         @(negedge clk);
      end
`ifdef SBLK_ACT_FEEDER_REQ_QUEUE_EN
      chk("queued vld count",     32'(nv),    32'd16);
      chk("queued drop count",    32'(nd),    32'd0);
      chk("queued restart cycle", 32'(ninth), 32'd11);
`else
      chk("dropped vld count",    32'(nv),    32'd8);
      chk("dropped drop count",   32'(nd),    32'd1);
      chk("dropped no 2nd batch", 32'(ninth), 32'd0);
`endif

      // inst_en at word 5 aborts the burst.
      load_inst(2, 2, 2, 12'h200);
      run_batch(12'h200, 16, "pre-abort");
      act_data_in_req = 1'b1;
      @(negedge clk);
      act_data_in_req = 1'b0;
      repeat (5) @(negedge clk);
      inst_data = {5'd2, 5'd3, 5'd2, 9'd7, 4'd2};
      src_base  = 12'h400;
      inst_en   = 1'b1;
      @(negedge clk);
      inst_en = 1'b0;
      chk("abort busy",          32'(busy),            32'd0);
      chk("abort in-flight vld", 32'(act_data_in_vld), 32'd1);
      chk("abort in-flight data", 32'(act_data), 32'(mem_val(12'h215)));
      nv = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (act_data_in_vld) nv++;
      end
      chk("abort extra vld", 32'(nv), 32'd0);
      run_batch(12'h400, 16, "abort new base");

      // Reset in the middle of a burst.
      load_inst(2, 3, 1, 12'h100);
      act_data_in_req = 1'b1;
      @(negedge clk);
      act_data_in_req = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("mid rst");
      rst = 1'b0;
      @(negedge clk);

      // Randomized instructions against the batch-address model.
      for (int it = 0; it < 12; it++) begin
         tn   = int'($urandom_range(0, 15));
         tp   = int'($urandom_range(0, 6));
         lp   = int'($urandom_range(0, 3));
         base = 12'($urandom);
         load_inst(tn, tp, lp, base);
         len  = tp * tn * 4;
         lpe  = (lp == 0) ? 1 : lp;
         nreq = int'($urandom_range(1, 4));
         for (int k = 0; k < nreq; k++) begin
            run_batch(12'(32'(base) + (k % lpe) * len), len, "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
